// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-port controller.
// Requester indices double as the bit positions in the arbiter's req/gnt vectors.
package rf_ctrl_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] RF_ZERO_ADDR = '0;

  localparam int unsigned REQ_EXE = 0;
  localparam int unsigned REQ_LSU = 1;

  typedef enum logic {
    PRIO_EXE = 1'b0,
    PRIO_LSU = 1'b1
  } prio_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, priority flips to the loser
// of each grant so neither requester waits more than one cycle behind the other.
module rr_arb2
  import rf_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  prio_e prio_q, prio_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= PRIO_EXE;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Grants are held off while reset is high so no handshake completes into a dropped write.
  always_comb begin
    gnt    = '0;
    prio_d = prio_q;
    if (!reset) begin
      if (req == 2'b11) begin
        gnt = (prio_q == PRIO_EXE) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
      if (gnt[REQ_EXE]) begin
        prio_d = PRIO_LSU;
      end else if (gnt[REQ_LSU]) begin
        prio_d = PRIO_EXE;
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// Shares the single reg_file write port between execute and load writeback,
// registers the winning write (x0 suppressed) and forwards it onto both read ports.
module reg_file_wr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned W = RF_ADDR_W,
  parameter int unsigned B = RF_DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [W-1:0] addr0,
  input  logic [B-1:0] data0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [W-1:0] addr1,
  input  logic [B-1:0] data1,
  output logic         gnt1,
  output logic         rf_wr_en,
  output logic [W-1:0] rf_w_addr,
  output logic [B-1:0] rf_w_data,
  input  logic [W-1:0] r_addr_A,
  input  logic [W-1:0] r_addr_B,
  input  logic [B-1:0] rf_r_data_A,
  input  logic [B-1:0] rf_r_data_B,
  output logic [B-1:0] r_data_A,
  output logic [B-1:0] r_data_B
);

  logic [1:0]   gnt;
  logic         grant_any;
  logic [W-1:0] g_addr;
  logic [B-1:0] g_data;

  logic         wr_en_q, wr_en_d;
  logic [W-1:0] w_addr_q, w_addr_d;
  logic [B-1:0] w_data_q, w_data_d;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({req1, req0}),
    .gnt   (gnt)
  );

  always_comb begin
    gnt0      = gnt[REQ_EXE];
    gnt1      = gnt[REQ_LSU];
    grant_any = |gnt;
    g_addr    = gnt[REQ_LSU] ? addr1 : addr0;
    g_data    = gnt[REQ_LSU] ? data1 : data0;
  end

  // A grant to x0 still completes the handshake; only the write enable is suppressed.
  always_comb begin
    wr_en_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (grant_any) begin
      wr_en_d  = (g_addr != '0);
      w_addr_d = g_addr;
      w_data_d = g_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

  always_comb begin
    rf_wr_en  = wr_en_q;
    rf_w_addr = w_addr_q;
    rf_w_data = w_data_q;
  end

  // Covers only the cycle between registering a write and reg_file committing it.
  always_comb begin
    r_data_A = rf_r_data_A;
    r_data_B = rf_r_data_B;
    if (wr_en_q && (w_addr_q == r_addr_A) && (r_addr_A != '0)) begin
      r_data_A = w_data_q;
    end
    if (wr_en_q && (w_addr_q == r_addr_B) && (r_addr_B != '0)) begin
      r_data_B = w_data_q;
    end
  end

endmodule
